id_stage: RTL and testbench

- Instruction-decode stage directly downstream of the fetch unit. Consumes the 32-bit instruction and PC each cycle.
- Holds them in an IF/ID pipeline register and decodes MIPS-style fields and control signals.
- Reads two operands from a 32x32 register file written by the write-back path.
- Provides stall and flush control so hazard and branch logic can freeze or squash the held instruction.

---
 rtl/id_pkg.sv | 29 ++
 rtl/id_reg_file.sv | 42 ++++
 rtl/id_stage.sv | 148 ++++++++++++++
 tb/tb_id_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: shared widths, opcodes, ALU_OP encodings and control bundle for the decode stage
package id_pkg;
    localparam int DATA_W  = 32;
    localparam int REG_CNT = 32;
    localparam int RADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;
endpackage

// File: rtl/id_reg_file.sv
// reg_file: 32x32 register file, two async read ports, one sync write port, r0 hardwired to zero; WB_BYPASS_EN adds write-through reads
module reg_file #(
    parameter int DATA_W  = id_pkg::DATA_W,
    parameter int REG_CNT = id_pkg::REG_CNT,
    parameter int RADDR_W = id_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr_a,
    input  logic [RADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]  rdata_a,
    output logic [DATA_W-1:0]  rdata_b
);
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];
    logic              wr_live;

    assign wr_live = we && (waddr != '0);

    // next register contents: one entry updated per write, r0 never touched
    always_comb begin
        regs_d = regs_q;
        if (wr_live) regs_d[waddr] = wdata;
    end

    // storage, cleared immediately by reset so no in-flight write survives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) regs_q <= '{default: '0};
        else          regs_q <= regs_d;
    end

`ifdef WB_BYPASS_EN
    assign rdata_a = (raddr_a == '0) ? '0 : (wr_live && waddr == raddr_a) ? wdata : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : (wr_live && waddr == raddr_b) ? wdata : regs_q[raddr_b];
`else
    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
`endif
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID pipeline register with stall/flush, MIPS field/control decode and register-file read (WB_BYPASS_EN enables write-through reads)
module id_stage #(
    parameter int DATA_W  = id_pkg::DATA_W,
    parameter int REG_CNT = id_pkg::REG_CNT,
    parameter int RADDR_W = id_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  if_instr,
    input  logic [DATA_W-1:0]  if_pc,
    input  logic               if_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               id_valid,
    output logic [DATA_W-1:0]  id_pc_plus4,
    output logic [DATA_W-1:0]  rs_data,
    output logic [DATA_W-1:0]  rt_data,
    output logic [DATA_W-1:0]  imm_sext,
    output logic [RADDR_W-1:0] rs_addr,
    output logic [RADDR_W-1:0] rt_addr,
    output logic [RADDR_W-1:0] rd_addr,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [DATA_W-1:0]  jump_target,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               alu_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               branch,
    output logic               jump,
    output logic [1:0]         alu_op,
    output logic               illegal
);
    import id_pkg::*;

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    ctrl_t             ctrl;
    logic              ill;

    // IF/ID next state: flush squashes to a NOP bubble and beats stall
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = if_instr;
            pc_d    = if_pc;
            valid_d = if_valid;
        end
    end

    // IF/ID register, reset to an invalid NOP at pc 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // opcode decode; a bubble drives every control low and is never illegal
    always_comb begin
        ctrl = '0;
        ill  = 1'b0;
        if (valid_q) begin
            case (instr_q[31:26])
                OP_RTYPE: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                OP_LW: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.alu_op     = ALU_ADD;
                end
                OP_SW: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                end
                OP_BEQ: begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                end
                OP_ADDI: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                end
                OP_J:    ctrl.jump = 1'b1;
                default: ill = 1'b1;
            endcase
        end
    end

    assign id_valid    = valid_q;
    assign id_pc_plus4 = pc_q + DATA_W'(4);
    assign rs_addr     = instr_q[25:21];
    assign rt_addr     = instr_q[20:16];
    assign rd_addr     = instr_q[15:11];
    assign shamt       = instr_q[10:6];
    assign funct       = instr_q[5:0];
    assign imm_sext    = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
    assign jump_target = {id_pc_plus4[31:28], instr_q[25:0], 2'b00};
    assign reg_write   = ctrl.reg_write;
    assign reg_dst     = ctrl.reg_dst;
    assign alu_src     = ctrl.alu_src;
    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign branch      = ctrl.branch;
    assign jump        = ctrl.jump;
    assign alu_op      = ctrl.alu_op;
    assign illegal     = ill;

    reg_file #(
        .DATA_W (DATA_W),
        .REG_CNT(REG_CNT),
        .RADDR_W(RADDR_W)
    ) u_rf (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr_a(rs_addr),
        .raddr_b(rt_addr),
        .rdata_a(rs_data),
        .rdata_b(rt_data)
    );
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage (expects WB_BYPASS_EN to match the RTL build)
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_instr, if_pc;
    logic        if_valid, stall, flush, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc_plus4, rs_data, rt_data, imm_sext, jump_target;
    logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
    logic [5:0]  funct;
    logic        reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, branch, jump;
    logic [1:0]  alu_op;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    id_stage dut (
        .clk(clk), .reset_n(reset_n), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .rs_data(rs_data), .rt_data(rt_data),
        .imm_sext(imm_sext), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .shamt(shamt), .funct(funct), .jump_target(jump_target), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .alu_op(alu_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; if_instr = '0; if_pc = '0; if_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #12;
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_reg_write", 32'(reg_write), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_rs_data", rs_data, 0);
        chk("rst_imm", imm_sext, 0);
        chk("rst_jtarget", jump_target, 0);

        reset_n = 1'b1; if_instr = 32'h8C220004; if_pc = 32'h100; if_valid = 1'b1;
        tick();
        chk("lw_valid", 32'(id_valid), 1);
        chk("lw_mem_read", 32'(mem_read), 1);
        chk("lw_mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw_alu_src", 32'(alu_src), 1);
        chk("lw_reg_write", 32'(reg_write), 1);
        chk("lw_mem_write", 32'(mem_write), 0);
        chk("lw_alu_op", 32'(alu_op), 0);
        chk("lw_rs_addr", 32'(rs_addr), 1);
        chk("lw_rt_addr", 32'(rt_addr), 2);
        chk("lw_imm", imm_sext, 32'h4);
        chk("lw_pc4", id_pc_plus4, 32'h104);

        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; if_instr = 32'h00A53020;
        tick();
        chk("add_reg_dst", 32'(reg_dst), 1);
        chk("add_alu_op", 32'(alu_op), 2);
        chk("add_rd_addr", 32'(rd_addr), 6);
        chk("add_funct", 32'(funct), 32'h20);
        chk("add_rs_data", rs_data, 32'hDEADBEEF);
        chk("add_rt_data", rt_data, 32'hDEADBEEF);

        wb_addr = 5'd0; wb_data = 32'h1234; if_instr = 32'h00001020;
        tick();
        chk("r0_bypass_zero", rs_data, 0);
        wb_en = 1'b0;
        tick();
        chk("r0_zero", rt_data, 0);

        if_instr = 32'h10A70003; if_pc = 32'h200;
        tick();
        chk("beq_branch", 32'(branch), 1);
        chk("beq_alu_op", 32'(alu_op), 1);
        chk("beq_imm", imm_sext, 32'h3);
        chk("beq_rs_data", rs_data, 32'hDEADBEEF);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_instr = 32'h8C000000 + 32'(i);
            if_pc = 32'h300 + 32'(i * 4);
            tick();
            chk("stall_branch", 32'(branch), 1);
            chk("stall_pc4", id_pc_plus4, 32'h204);
            chk("stall_imm", imm_sext, 32'h3);
        end

        flush = 1'b1;
        tick();
        chk("flush_valid", 32'(id_valid), 0);
        chk("flush_branch", 32'(branch), 0);
        chk("flush_alu_op", 32'(alu_op), 0);
        chk("flush_illegal", 32'(illegal), 0);
        chk("flush_rs_addr", 32'(rs_addr), 0);
        stall = 1'b0; flush = 1'b0;

        if_instr = 32'hFC000000; if_pc = 32'h400;
        tick();
        chk("ill_illegal", 32'(illegal), 1);
        chk("ill_reg_write", 32'(reg_write), 0);
        chk("ill_mem_write", 32'(mem_write), 0);

        if_instr = 32'h2022FFFF;
        tick();
        chk("addi_imm", imm_sext, 32'hFFFFFFFF);
        chk("addi_alu_src", 32'(alu_src), 1);
        chk("addi_reg_write", 32'(reg_write), 1);
        chk("addi_reg_dst", 32'(reg_dst), 0);

        if_instr = 32'h08000040; if_pc = 32'hFFFFFFFC;
        tick();
        chk("j_jump", 32'(jump), 1);
        chk("j_pc4_wrap", id_pc_plus4, 0);
        chk("j_target", jump_target, 32'h100);

        if_instr = 32'hAC000000; if_valid = 1'b0;
        tick();
        chk("inv_valid", 32'(id_valid), 0);
        chk("inv_mem_write", 32'(mem_write), 0);
        chk("inv_illegal", 32'(illegal), 0);

        if_instr = 32'h00E00000; if_valid = 1'b1; if_pc = 32'h500;
        tick();
        chk("r7_old", rs_data, 0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFEF00D;
        #1;
`ifdef WB_BYPASS_EN
        chk("r7_same_cycle", rs_data, 32'hCAFEF00D);
`else
        chk("r7_same_cycle", rs_data, 0);
`endif
        tick();
        wb_en = 1'b0;
        chk("r7_next_cycle", rs_data, 32'hCAFEF00D);

        chk("pre_rst_valid", 32'(id_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(id_valid), 0);
        chk("async_rst_r7", rs_data, 0);
        reset_n = 1'b1; if_instr = 32'h00A00000;
        tick();
        chk("post_rst_valid", 32'(id_valid), 1);
        chk("post_rst_r5", rs_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
